// File: rtl/ring_arb_pkg.sv
// Shared types and limits for the rotating-priority ring arbiter.
// No logic; pure declarations.
// No flow control.
package ring_arb_pkg;

    // Legal range for the number of requesters
    localparam int WID_MIN = 2;
    localparam int WID_MAX = 32;

    // Arbiter control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        REL   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority pick: first set req bit at or after the one-hot pri position, wrapping.
// Latency: purely combinational.
// Backpressure: none; expects a one-hot pri (the caller sanitises it).
module rr_pick #(
    parameter int WID   = 8,
    parameter int IDX_W = $clog2(WID)
) (
    input  logic [WID-1:0]   i_pri,
    input  logic [WID-1:0]   i_req,
    output logic [WID-1:0]   o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_ptr;

    // Encode the one-hot priority pointer into a start index
    always_comb begin
        w_ptr = '0;
        for (int i = 0; i < WID; i++) begin
            if (i_pri[i]) begin
                w_ptr = IDX_W'(i);
            end
        end
    end

    // Scan WID positions starting at the pointer; the first requester found wins
    always_comb begin
        int j;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        j        = 0;
        for (int k = 0; k < WID; k++) begin
            j = int'(w_ptr) + k;
            if (j >= WID) begin
                j = j - WID;
            end
            if (!o_any && i_req[j[IDX_W-1:0]]) begin
                o_any                    = 1'b1;
                o_onehot[j[IDX_W-1:0]]   = 1'b1;
                o_idx                    = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ring_arbiter.sv
// Ring arbiter: rotating-priority grant held until release or (optionally) timeout; adv rotates upstream pri.
// Latency: one cycle req->gnt; one dead REL cycle after every release before the next pick.
// Backpressure: ce low freezes all state; an owner keeps the grant until its req drops (or timeout with RING_ARB_TIMEOUT_EN).
module ring_arbiter
    import ring_arb_pkg::*;
#(
    parameter int WID      = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic [WID-1:0]          pri,
    input  logic [WID-1:0]          req,
    output logic [WID-1:0]          gnt,
    output logic [$clog2(WID)-1:0]  gnt_idx,
    output logic                    gnt_vld,
    output logic                    adv,
    output logic                    tmo,
    output logic                    pri_err
);

    localparam int IDX_W = $clog2(WID);

    if (WID < WID_MIN || WID > WID_MAX) begin : g_bad_wid
        $error("ring_arbiter: WID out of range");
    end

    arb_state_t       r_state;
    logic [WID-1:0]   r_gnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_vld;
    logic             r_adv;
    logic             r_tmo;
    logic             r_pri_err;

    logic             w_pri_ok;
    logic [WID-1:0]   w_pri_eff;
    logic [WID-1:0]   w_pick;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_any;

    // A malformed pointer (zero or multi-hot) falls back to requester 0
    always_comb begin
        w_pri_ok  = (pri != '0) && ((pri & (pri - 1'b1)) == '0);
        w_pri_eff = w_pri_ok ? pri : WID'(1);
    end

    rr_pick #(
        .WID   (WID),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_pri    (w_pri_eff),
        .i_req    (req),
        .o_onehot (w_pick),
        .o_idx    (w_pick_idx),
        .o_any    (w_any)
    );

`ifdef RING_ARB_TIMEOUT_EN
    localparam int               CNT_W     = $clog2(HOLD_MAX + 1);
    // Counter is 0 in the first grant cycle, so HOLD_MAX-1 marks the last permitted cycle
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    logic [CNT_W-1:0] r_cnt;
`else
    logic w_unused_hold;
    assign w_unused_hold = (HOLD_MAX != 0);
`endif

    // Arbiter FSM with registered grant, release pulses and sticky pointer error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_idx     <= '0;
            r_vld     <= 1'b0;
            r_adv     <= 1'b0;
            r_tmo     <= 1'b0;
            r_pri_err <= 1'b0;
`ifdef RING_ARB_TIMEOUT_EN
            r_cnt     <= '0;
`endif
        end else if (!ce) begin
            // Frozen: pulses never stretch while the enable is low
            r_adv <= 1'b0;
            r_tmo <= 1'b0;
        end else begin
            r_adv <= 1'b0;
            r_tmo <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_pri_ok) begin
                        r_pri_err <= 1'b1;
                    end
                    if (w_any) begin
                        r_gnt   <= w_pick;
                        r_idx   <= w_pick_idx;
                        r_vld   <= 1'b1;
                        r_state <= GRANT;
`ifdef RING_ARB_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                GRANT: begin
                    // A dropping request wins over a coincident timeout
                    if (!req[r_idx]) begin
                        r_gnt   <= '0;
                        r_idx   <= '0;
                        r_vld   <= 1'b0;
                        r_adv   <= 1'b1;
                        r_state <= REL;
`ifdef RING_ARB_TIMEOUT_EN
                    end else if (r_cnt == HOLD_LAST) begin
                        r_gnt   <= '0;
                        r_idx   <= '0;
                        r_vld   <= 1'b0;
                        r_adv   <= 1'b1;
                        r_tmo   <= 1'b1;
                        r_state <= REL;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
`endif
                    end
                end
                REL: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef RING_ARB_TIMEOUT_EN
    assign tmo     = r_tmo;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = r_tmo;
    assign tmo          = 1'b0;
`endif
    assign gnt     = r_gnt;
    assign gnt_idx = r_idx;
    assign gnt_vld = r_vld;
    assign adv     = r_adv;
    assign pri_err = r_pri_err;

endmodule

// File: tb/tb_ring_arbiter.sv
module tb_ring_arbiter;

    localparam int W    = 8;
    localparam int HOLD = 15;
`ifdef RING_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         ce;
    logic [W-1:0] pri;
    logic [W-1:0] req;
    logic [W-1:0] gnt;
    logic [2:0]   gnt_idx;
    logic         gnt_vld;
    logic         adv;
    logic         tmo;
    logic         pri_err;

    int checks = 0;
    int errors = 0;

    // Reference model: current owner (-1 = none), dead-cycle flag, visible grant cycles
    int m_owner = -1;
    bit m_rel   = 1'b0;
    int m_held  = 0;
    bit m_adv   = 1'b0;
    bit m_tmo   = 1'b0;
    bit m_err   = 1'b0;

    ring_arbiter #(.WID(W), .HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .pri     (pri),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .adv     (adv),
        .tmo     (tmo),
        .pri_err (pri_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_pick(logic [W-1:0] p, logic [W-1:0] r);
        int start = 0;
        if ($countones(p) == 1) begin
            for (int i = 0; i < W; i++) if (p[i]) start = i;
        end
        for (int k = 0; k < W; k++) begin
            if (r[(start + k) % W]) return (start + k) % W;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (!rst_n) begin
            m_owner = -1; m_rel = 0; m_held = 0;
            m_adv = 0; m_tmo = 0; m_err = 0;
        end else if (!ce) begin
            m_adv = 0; m_tmo = 0;
        end else begin
            m_adv = 0; m_tmo = 0;
            if (m_rel) begin
                m_rel = 0;
            end else if (m_owner < 0) begin
                if ($countones(pri) != 1) m_err = 1;
                w = ref_pick(pri, req);
                if (w >= 0) begin
                    m_owner = w;
                    m_held  = 1;
                end
            end else if (!req[m_owner]) begin
                m_owner = -1; m_rel = 1; m_adv = 1;
            end else if (TMO_EN && m_held == HOLD) begin
                m_owner = -1; m_rel = 1; m_adv = 1; m_tmo = 1;
            end else begin
                m_held++;
            end
        end
    endtask

    // One clock: model follows the edge, outputs are sampled 1ns later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ce    = 1'b1;
        req   = '0;
        pri   = 8'h01;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce    = 1'b1;
        req   = 8'hFF;
        pri   = 8'h00;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (gnt !== 8'h00 || gnt_vld !== 1'b0 || gnt_idx !== 3'd0) begin
                errors++;
                $display("FAIL reset_gnt cyc %0d: gnt=%h vld=%b idx=%0d, want 00/0/0", c, gnt, gnt_vld, gnt_idx);
            end
            checks++;
            if (adv !== 1'b0 || tmo !== 1'b0 || pri_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags cyc %0d: adv=%b tmo=%b pri_err=%b, want 0/0/0", c, adv, tmo, pri_err);
            end
        end
        rst_n = 1'b1;
        req   = '0;
        pri   = 8'h01;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        pri = 8'h40;
        req = 8'h05;
        checks++;
        if (gnt !== 8'h00) begin
            errors++;
            $display("FAIL wrap_pre: gnt=%h before edge, want 00", gnt);
        end
        tick();
        checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_vld !== 1'b1) begin
            errors++;
            $display("FAIL wrap_grant: gnt=%h idx=%0d vld=%b, want 01/0/1", gnt, gnt_idx, gnt_vld);
        end
        req = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_release();
        do_reset();
        pri = 8'h01;
        req = 8'h08;
        tick();
        checks++;
        if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
            errors++;
            $display("FAIL rel_grant: gnt=%h idx=%0d, want 08/3", gnt, gnt_idx);
        end
        // Others arrive, pri moves: no preemption
        req = 8'h1F;
        pri = 8'h02;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (gnt !== 8'h08 || adv !== 1'b0) begin
                errors++;
                $display("FAIL rel_hold cyc %0d: gnt=%h adv=%b, want 08/0", c, gnt, adv);
            end
        end
        pri = 8'h01;
        req = 8'h17;
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_vld !== 1'b0 || adv !== 1'b1 || tmo !== 1'b0) begin
            errors++;
            $display("FAIL rel_drop: gnt=%h vld=%b adv=%b tmo=%b, want 00/0/1/0", gnt, gnt_vld, adv, tmo);
        end
        tick();
        checks++;
        if (gnt !== 8'h00 || adv !== 1'b0) begin
            errors++;
            $display("FAIL rel_dead: gnt=%h adv=%b, want 00/0", gnt, adv);
        end
        tick();
        checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            errors++;
            $display("FAIL rel_next: gnt=%h idx=%0d, want 01/0", gnt, gnt_idx);
        end
        req = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_timeout();
        do_reset();
        pri = 8'h01;
        req = 8'h04;
        tick();
`ifdef RING_ARB_TIMEOUT_EN
        for (int c = 1; c < HOLD; c++) begin
            tick();
            checks++;
            if (gnt !== 8'h04 || tmo !== 1'b0 || adv !== 1'b0) begin
                errors++;
                $display("FAIL tmo_hold cyc %0d: gnt=%h tmo=%b adv=%b, want 04/0/0", c, gnt, tmo, adv);
            end
        end
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_vld !== 1'b0 || adv !== 1'b1 || tmo !== 1'b1) begin
            errors++;
            $display("FAIL tmo_revoke: gnt=%h vld=%b adv=%b tmo=%b, want 00/0/1/1", gnt, gnt_vld, adv, tmo);
        end
        tick();
        checks++;
        if (adv !== 1'b0 || tmo !== 1'b0 || gnt !== 8'h00) begin
            errors++;
            $display("FAIL tmo_pulse: adv=%b tmo=%b gnt=%h, want 0/0/00", adv, tmo, gnt);
        end
        tick();
        // Regranted; now drop the request exactly on the timeout edge
        for (int c = 1; c < HOLD; c++) tick();
        req = '0;
        tick();
        checks++;
        if (gnt !== 8'h00 || adv !== 1'b1 || tmo !== 1'b0) begin
            errors++;
            $display("FAIL tmo_coincide: gnt=%h adv=%b tmo=%b, want 00/1/0", gnt, adv, tmo);
        end
`else
        for (int c = 1; c < 40; c++) begin
            tick();
            checks++;
            if (gnt !== 8'h04 || tmo !== 1'b0 || adv !== 1'b0) begin
                errors++;
                $display("FAIL notmo_hold cyc %0d: gnt=%h tmo=%b adv=%b, want 04/0/0", c, gnt, tmo, adv);
            end
        end
        req = '0;
        tick();
        checks++;
        if (gnt !== 8'h00 || adv !== 1'b1 || tmo !== 1'b0) begin
            errors++;
            $display("FAIL notmo_release: gnt=%h adv=%b tmo=%b, want 00/1/0", gnt, adv, tmo);
        end
`endif
        req = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_bad_pri();
        do_reset();
        pri = 8'h00;
        req = 8'h80;
        tick();
        checks++;
        if (gnt !== 8'h80 || gnt_idx !== 3'd7 || pri_err !== 1'b1) begin
            errors++;
            $display("FAIL badpri_grant: gnt=%h idx=%0d pri_err=%b, want 80/7/1", gnt, gnt_idx, pri_err);
        end
        req = '0;
        tick(); tick(); tick();
        // Multi-hot pointer also falls back to bit 0
        pri = 8'h41;
        req = 8'h82;
        tick();
        checks++;
        if (gnt !== 8'h02 || gnt_idx !== 3'd1) begin
            errors++;
            $display("FAIL badpri_multihot: gnt=%h idx=%0d, want 02/1", gnt, gnt_idx);
        end
        req = '0;
        pri = 8'h01;
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (pri_err !== 1'b1) begin
            errors++;
            $display("FAIL badpri_sticky: pri_err=%b, want 1", pri_err);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (pri_err !== 1'b0) begin
            errors++;
            $display("FAIL badpri_clear: pri_err=%b after reset, want 0", pri_err);
        end
        tick();
    endtask

    task automatic test_ce_gating();
        do_reset();
        pri = 8'h01;
        req = 8'h04;
        tick();
        for (int c = 0; c < 5; c++) tick();
        ce  = 1'b0;
        req = 8'h0C;
        pri = 8'h10;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (gnt !== 8'h04 || gnt_vld !== 1'b1 || adv !== 1'b0 || tmo !== 1'b0) begin
                errors++;
                $display("FAIL ce_freeze cyc %0d: gnt=%h vld=%b adv=%b tmo=%b, want 04/1/0/0", c, gnt, gnt_vld, adv, tmo);
            end
        end
        ce = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            checks++;
            if (gnt !== 8'h04 || tmo !== 1'b0) begin
                errors++;
                $display("FAIL ce_resume cyc %0d: gnt=%h tmo=%b, want 04/0", c, gnt, tmo);
            end
        end
`ifdef RING_ARB_TIMEOUT_EN
        tick();
        checks++;
        if (gnt !== 8'h00 || adv !== 1'b1 || tmo !== 1'b1) begin
            errors++;
            $display("FAIL ce_timeout: gnt=%h adv=%b tmo=%b, want 00/1/1", gnt, adv, tmo);
        end
`else
        ce  = 1'b0;
        req = 8'h08;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (gnt !== 8'h04 || adv !== 1'b0) begin
                errors++;
                $display("FAIL ce_drop_frozen cyc %0d: gnt=%h adv=%b, want 04/0", c, gnt, adv);
            end
        end
        ce = 1'b1;
        tick();
        checks++;
        if (gnt !== 8'h00 || adv !== 1'b1) begin
            errors++;
            $display("FAIL ce_release: gnt=%h adv=%b, want 00/1", gnt, adv);
        end
`endif
        req = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_random();
        logic [W-1:0] exp_gnt;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            // Stimulus for the next edge: sparse request toggles, upstream ring rotation on adv
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            end
            if (m_adv) pri = {pri[W-2:0], pri[W-1]};
            if ($urandom_range(0, 59) == 0) pri = W'($urandom);
            else if ($urandom_range(0, 29) == 0) pri = W'(1) << $urandom_range(0, W-1);
            ce    = ($urandom_range(0, 6) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
            exp_gnt = (m_owner >= 0) ? (W'(1) << m_owner) : '0;
            checks++;
            if (gnt !== exp_gnt || gnt_vld !== (m_owner >= 0)) begin
                errors++;
                $display("FAIL rnd_gnt cyc %0d: gnt=%h vld=%b, want %h/%b", c, gnt, gnt_vld, exp_gnt, (m_owner >= 0));
            end
            if (m_owner >= 0) begin
                checks++;
                if (gnt_idx !== m_owner[2:0]) begin
                    errors++;
                    $display("FAIL rnd_idx cyc %0d: idx=%0d, want %0d", c, gnt_idx, m_owner);
                end
            end
            checks++;
            if (adv !== m_adv || tmo !== m_tmo || pri_err !== m_err) begin
                errors++;
                $display("FAIL rnd_flags cyc %0d: adv=%b tmo=%b pri_err=%b, want %b/%b/%b", c, adv, tmo, pri_err, m_adv, m_tmo, m_err);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ce    = 1'b1;
        req   = '0;
        pri   = 8'h01;
        test_reset();
        test_wrap();
        test_release();
        test_timeout();
        test_bad_pri();
        test_ce_gating();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_arbiter.md
RING_ARBITER -- requirements
Module: ring_arbiter

Interface
REQ-001 SHALL have parameter WID, default 8, number of requesters; legal range 2..32.
REQ-002 SHALL have parameter HOLD_MAX, default 15, maximum grant cycles before forced release.
REQ-003 SHALL use one clock and a synchronous, active-low reset, with clock and reset ports listed first.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst_n  input  1  synchronous active-low reset.
REQ-006 Port ce  input  1  clock enable; when low, all state and outputs hold and adv stays 0.
REQ-007 Port pri  input  WID  one-hot priority pointer, driven by the upstream ring counter q.
REQ-008 Port req  input  WID  level request per requester.
REQ-009 Port gnt  output  WID  registered one-hot grant.
REQ-010 Port gnt_idx  output  $clog2(WID)  binary index of the granted requester.
REQ-011 Port gnt_vld  output  1  high while any grant is held.
REQ-012 Port adv  output  1  one-cycle pulse that drives the ring counter cntr input to rotate priority.
REQ-013 Port tmo  output  1  one-cycle pulse when a grant is revoked by timeout.
REQ-014 Port pri_err  output  1  sticky flag set when pri is sampled non-one-hot in IDLE.

Function
REQ-015 SHALL implement states IDLE, GRANT and REL.
REQ-016 In IDLE with ce=1 and |req, SHALL pick the first set req bit, searching from the pri index p upward (p, p+1, ..., WID-1, 0, ..., p-1).
REQ-017 SHALL register that pick into gnt/gnt_idx/gnt_vld on the same edge and enter GRANT, giving a latency of one cycle from req to gnt.
REQ-018 In IDLE with req=0, SHALL stay in IDLE with gnt=0.
REQ-019 In GRANT, SHALL hold gnt constant while req[gnt_idx]=1 and the hold counter is below HOLD_MAX.
REQ-020 The hold counter SHALL clear on grant and increment once per ce cycle in GRANT.
REQ-021 When req[gnt_idx]=0 in GRANT, SHALL clear gnt/gnt_vld, pulse adv for one cycle and enter REL.
REQ-022 When the hold counter reaches HOLD_MAX with the request still high, SHALL clear the grant, pulse adv and tmo together and enter REL.
REQ-023 REL SHALL last exactly one cycle, with gnt=0, then return to IDLE; this dead cycle lets pri rotate before the next pick.
REQ-024 Changes on pri outside IDLE SHALL be ignored.
REQ-025 A non-one-hot pri in IDLE, including all-zero, SHALL be treated as pri=bit0 and SHALL set pri_err.
REQ-026 Requests for other requesters arriving during GRANT SHALL NOT preempt the current grant.
REQ-027 A deasserting request and a timeout in the same cycle SHALL be reported as a normal release (tmo=0).

Reset
REQ-028 When rst_n=0 at a rising edge, SHALL enter IDLE, clear the hold counter, and drive gnt=0, gnt_idx=0, gnt_vld=0, adv=0, tmo=0 and pri_err=0.
REQ-029 Reset SHALL take precedence over ce and abort any grant in progress without pulsing adv.

Configuration
REQ-030 With macro RING_ARB_TIMEOUT_EN defined, SHALL include the hold counter and timeout behaviour of REQ-020, REQ-022 and REQ-027.
REQ-031 Without RING_ARB_TIMEOUT_EN, SHALL omit the counter, hold the grant until its request drops, tie tmo to 0 and ignore HOLD_MAX.

Structure
REQ-032 Package ring_arb_pkg SHALL hold the state enum (IDLE, GRANT, REL) and the WID range constants.
REQ-033 The rotating priority pick SHALL be a combinational sub-module rr_pick (inputs pri and req; outputs one-hot, index and any).
REQ-034 The hold counter width SHALL be $clog2(HOLD_MAX+1).

Verification
REQ-035 Reset: with rst_n=0 and req=8'hFF, SHALL show gnt=0, adv=0 and pri_err=0 throughout.
REQ-036 Priority wrap: with pri=8'h40 and req=8'h05, SHALL grant 8'h01 (gnt_idx=0) one cycle after req.
REQ-037 Release: with a grant on idx 3 and req[3] dropping, SHALL clear gnt on the next edge with a single adv pulse, then one REL cycle, then IDLE.
REQ-038 Timeout (RING_ARB_TIMEOUT_EN, HOLD_MAX=15): with req[2] held high, SHALL revoke after 15 grant cycles with adv=tmo=1 for one cycle.
REQ-039 Bad pointer: with pri=8'h00 and req=8'h80, SHALL grant idx 7, set pri_err, and keep pri_err set until reset.
REQ-040 ce gating: with ce=0 mid-grant for 5 cycles, SHALL keep gnt and the counter frozen and adv=0.
